stage_memory: RTL and testbench

- MEM pipeline stage. It consumes the EX/MEM pipeline register (mem_* signals) and performs word load/store through a request/acknowledge data bus.
- It stalls the pipeline while an access is outstanding, then registers results into the MEM/WB pipeline register (wb_* signals).
- It sits between the execute stage and the writeback mux. It is the downstream end of the EX→MEM interface and the initiator on the data-memory bus.

---
 rtl/stage_memory.sv | 149 ++++++++++++++
 tb/tb_stage_memory.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_memory.sv
// MEM pipeline stage: issues word loads/stores on a req/ack data bus, stalls the
// pipeline while an access is outstanding, and registers results into MEM/WB.
module stage_memory #(
  parameter int unsigned ACK_TIMEOUT   = 255,
  parameter logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_clear,
  input  logic        mem_reg_write,
  input  logic        mem_mem_write,
  input  logic [1:0]  mem_result_src,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_write_data,
  input  logic [31:0] mem_pc_plus_4,
  input  logic [31:0] mem_imm_ext,
  input  logic [4:0]  mem_rd,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        mem_stall,
  output logic        bus_error,
  output logic        wb_reg_write,
  output logic [1:0]  wb_result_src,
  output logic [31:0] wb_alu_result,
  output logic [31:0] wb_read_data,
  output logic [31:0] wb_pc_plus_4,
  output logic [31:0] wb_imm_ext,
  output logic [4:0]  wb_rd
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int unsigned CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (ACK_TIMEOUT == 0) ? '0 : CNT_W'(ACK_TIMEOUT - 1);
  localparam bit TIMEOUT_EN = (ACK_TIMEOUT != 0);

  state_t            state_reg;
  state_t            state_next;
  logic [CNT_W-1:0]  cnt_reg;
  logic [31:0]       hold_reg;
  logic              load_reg;

  logic is_load;
  logic access;
  logic ack_hit;
  logic timeout_hit;

  assign is_load     = (mem_result_src == 2'b01);
  assign access      = mem_mem_write | is_load;
  assign ack_hit     = (state_reg == ST_BUSY) && bus_ack;
  assign timeout_hit = TIMEOUT_EN && (state_reg == ST_BUSY) && !bus_ack && (cnt_reg == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (access) state_next = ST_BUSY;
      ST_BUSY: if (ack_hit || timeout_hit) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // DONE never stalls: the held instruction retires into MEM/WB that cycle.
  always_comb begin
    mem_stall = 1'b0;
    case (state_reg)
      ST_IDLE: mem_stall = access;
      ST_BUSY: mem_stall = 1'b1;
      default: mem_stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || state_reg != ST_BUSY || ack_hit || timeout_hit) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_error <= 1'b0;
      load_reg  <= 1'b0;
      hold_reg  <= '0;
    end else begin
      if (state_reg == ST_IDLE && access) begin
        bus_req   <= 1'b1;
        bus_we    <= mem_mem_write;
        bus_addr  <= {mem_alu_result[31:2], 2'b00};
        bus_wdata <= mem_write_data;
        load_reg  <= is_load & ~mem_mem_write;
      end
      // An ack arriving on the last allowed cycle still wins over the timeout.
      if (ack_hit) begin
        bus_req <= 1'b0;
        if (load_reg) hold_reg <= bus_rdata;
      end else if (timeout_hit) begin
        bus_req   <= 1'b0;
        bus_error <= 1'b1;
        hold_reg  <= TIMEOUT_RDATA;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || wb_clear) begin
      wb_reg_write  <= 1'b0;
      wb_result_src <= '0;
      wb_alu_result <= '0;
      wb_read_data  <= '0;
      wb_pc_plus_4  <= '0;
      wb_imm_ext    <= '0;
      wb_rd         <= '0;
    end else if (mem_stall) begin
      wb_reg_write <= 1'b0;
      wb_rd        <= '0;
    end else begin
      wb_reg_write  <= mem_reg_write;
      wb_result_src <= mem_result_src;
      wb_alu_result <= mem_alu_result;
      wb_pc_plus_4  <= mem_pc_plus_4;
      wb_imm_ext    <= mem_imm_ext;
      wb_rd         <= mem_rd;
      if (is_load) wb_read_data <= hold_reg;
    end
  end

endmodule

// File: tb/tb_stage_memory.sv
// Bench for stage_memory: directed scenarios plus randomized instruction stream
// checked against a transaction-level latency/result model.
module tb_stage_memory;

  localparam int TB_TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst, wb_clear;
  logic        mem_reg_write, mem_mem_write;
  logic [1:0]  mem_result_src;
  logic [31:0] mem_alu_result, mem_write_data, mem_pc_plus_4, mem_imm_ext;
  logic [4:0]  mem_rd;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_ack, mem_stall, bus_error;
  logic        wb_reg_write;
  logic [1:0]  wb_result_src;
  logic [31:0] wb_alu_result, wb_read_data, wb_pc_plus_4, wb_imm_ext;
  logic [4:0]  wb_rd;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  stage_memory #(.ACK_TIMEOUT(TB_TIMEOUT), .TIMEOUT_RDATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .rst(rst), .wb_clear(wb_clear),
    .mem_reg_write(mem_reg_write), .mem_mem_write(mem_mem_write),
    .mem_result_src(mem_result_src), .mem_alu_result(mem_alu_result),
    .mem_write_data(mem_write_data), .mem_pc_plus_4(mem_pc_plus_4),
    .mem_imm_ext(mem_imm_ext), .mem_rd(mem_rd),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .mem_stall(mem_stall), .bus_error(bus_error),
    .wb_reg_write(wb_reg_write), .wb_result_src(wb_result_src),
    .wb_alu_result(wb_alu_result), .wb_read_data(wb_read_data),
    .wb_pc_plus_4(wb_pc_plus_4), .wb_imm_ext(wb_imm_ext), .wb_rd(wb_rd)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic set_instr(input logic rw, input logic mw, input logic [1:0] rs,
                           input logic [31:0] alu, input logic [31:0] wd,
                           input logic [31:0] pc4, input logic [31:0] imm, input logic [4:0] rd);
    mem_reg_write = rw; mem_mem_write = mw; mem_result_src = rs;
    mem_alu_result = alu; mem_write_data = wd; mem_pc_plus_4 = pc4;
    mem_imm_ext = imm; mem_rd = rd;
  endtask

  // Presents one instruction, plays the bus slave (ack on the ack_delay-th request
  // cycle, 0 = never) and returns observations once the instruction retires.
  task automatic run_instr(input logic rw, input logic mw, input logic [1:0] rs,
                           input logic [31:0] alu, input logic [31:0] wd,
                           input logic [31:0] pc4, input logic [31:0] imm, input logic [4:0] rd,
                           input int ack_delay, input logic [31:0] rdata, input bit clr, input bit noise,
                           output int stalls, output int busy, output logic [31:0] addr_o,
                           output logic we_o, output logic [31:0] wdata_o,
                           output bit stable, output bit bubble, output bit ok);
    bit done;
    stalls = 0; busy = 0; stable = 1'b1; bubble = 1'b0; ok = 1'b0; done = 1'b0;
    addr_o = '0; we_o = 1'b0; wdata_o = '0;
    set_instr(rw, mw, rs, alu, wd, pc4, imm, rd);
    for (int c = 0; c < 20; c++) begin
      if (bus_req === 1'b1) begin
        busy++;
        if (busy == 1) begin
          addr_o = bus_addr; we_o = bus_we; wdata_o = bus_wdata;
        end else if (bus_addr !== addr_o || bus_we !== we_o || bus_wdata !== wdata_o) begin
          stable = 1'b0;
        end
        bus_ack   = (busy == ack_delay);
        bus_rdata = (busy == ack_delay) ? rdata : $urandom;
      end else begin
        bus_ack   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        bus_rdata = $urandom;
      end
      @(negedge clk);
      if (c > 0 && wb_reg_write === 1'b0) bubble = 1'b1;
      if (mem_stall === 1'b1) stalls++;
      else begin
        wb_clear = clr;
        done = 1'b1;
      end
      @(posedge clk); #1;
      wb_clear = 1'b0;
      bus_ack  = 1'b0;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    $display("txn rs=%0d we=%0d addr=%h stalls=%0d busy=%0d wb_rd=%0d wb_read_data=%h err=%0d",
             rs, mw, alu, stalls, busy, wb_rd, wb_read_data, bus_error);
  endtask

  task automatic test_reset();
    rst = 1'b1; wb_clear = 1'b0; bus_ack = 1'b0; bus_rdata = '0;
    set_instr(1'b0, 1'b0, 2'b00, '0, '0, '0, '0, '0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    n_checks++; if ({bus_req, bus_we} !== 2'b00) begin n_fail++; $display("FAIL reset_req_we: got %b required 00", {bus_req, bus_we}); end
    n_checks++; if (bus_addr !== 32'h0 || bus_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_addr_wdata: got %h/%h required 0/0", bus_addr, bus_wdata); end
    n_checks++; if (bus_error !== 1'b0) begin n_fail++; $display("FAIL reset_bus_error: got %b required 0", bus_error); end
    n_checks++; if ({wb_reg_write, wb_result_src, wb_rd} !== 8'h0) begin n_fail++; $display("FAIL reset_wb_ctrl: got %h required 0", {wb_reg_write, wb_result_src, wb_rd}); end
    n_checks++; if ({wb_alu_result, wb_read_data, wb_pc_plus_4, wb_imm_ext} !== 128'h0) begin n_fail++; $display("FAIL reset_wb_data: got %h required 0", {wb_alu_result, wb_read_data, wb_pc_plus_4, wb_imm_ext}); end
    n_checks++; if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b required 0", mem_stall); end
  endtask

  task automatic test_alu();
    int st, bz; logic [31:0] a, w; logic we; bit stb, bub, ok;
    run_instr(1'b1, 1'b0, 2'b00, 32'h10, 32'h0, 32'h104, 32'h7, 5'd5, 0, 32'h0, 1'b0, 1'b0,
              st, bz, a, we, w, stb, bub, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL alu_retire: got no retire required retire within bound"); end
    n_checks++; if (st !== 0 || bz !== 0) begin n_fail++; $display("FAIL alu_no_stall: got stalls=%0d req=%0d required 0/0", st, bz); end
    n_checks++; if (wb_alu_result !== 32'h10 || wb_rd !== 5'd5 || wb_reg_write !== 1'b1) begin n_fail++; $display("FAIL alu_wb: got %h/%0d/%b required 10/5/1", wb_alu_result, wb_rd, wb_reg_write); end
    n_checks++; if (wb_pc_plus_4 !== 32'h104 || wb_imm_ext !== 32'h7) begin n_fail++; $display("FAIL alu_passthru: got %h/%h required 104/7", wb_pc_plus_4, wb_imm_ext); end
  endtask

  task automatic test_load();
    int st, bz; logic [31:0] a, w; logic we; bit stb, bub, ok;
    run_instr(1'b1, 1'b0, 2'b01, 32'h1003, 32'h0, 32'h40, 32'h0, 5'd7, 1, 32'hCAFE0001, 1'b0, 1'b0,
              st, bz, a, we, w, stb, bub, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL load_retire: got no retire required retire within bound"); end
    n_checks++; if (a !== 32'h1000 || we !== 1'b0) begin n_fail++; $display("FAIL load_bus: got addr=%h we=%b required 1000/0", a, we); end
    n_checks++; if (st !== 2) begin n_fail++; $display("FAIL load_stall_cycles: got %0d required 2", st); end
    n_checks++; if (wb_read_data !== 32'hCAFE0001 || wb_reg_write !== 1'b1 || wb_rd !== 5'd7) begin n_fail++; $display("FAIL load_wb: got %h/%b/%0d required CAFE0001/1/7", wb_read_data, wb_reg_write, wb_rd); end
    n_checks++; if (bub !== 1'b1) begin n_fail++; $display("FAIL load_bubble: got %b required 1", bub); end
  endtask

  task automatic test_store();
    int st, bz; logic [31:0] a, w; logic we; bit stb, bub, ok;
    run_instr(1'b0, 1'b1, 2'b00, 32'h2000, 32'h55AA, 32'h44, 32'h0, 5'd3, 3, 32'h0, 1'b0, 1'b1,
              st, bz, a, we, w, stb, bub, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL store_retire: got no retire required retire within bound"); end
    n_checks++; if (we !== 1'b1 || w !== 32'h55AA || a !== 32'h2000) begin n_fail++; $display("FAIL store_bus: got we=%b wdata=%h addr=%h required 1/55AA/2000", we, w, a); end
    n_checks++; if (stb !== 1'b1) begin n_fail++; $display("FAIL store_stable: got %b required 1", stb); end
    n_checks++; if (st !== 4 || bz !== 3) begin n_fail++; $display("FAIL store_stall_cycles: got %0d/%0d required 4/3", st, bz); end
    n_checks++; if (bus_error !== 1'b0 || wb_reg_write !== 1'b0) begin n_fail++; $display("FAIL store_err_rw: got %b/%b required 0/0", bus_error, wb_reg_write); end
    n_checks++; if (wb_read_data !== 32'hCAFE0001) begin n_fail++; $display("FAIL store_rdata_kept: got %h required CAFE0001", wb_read_data); end
  endtask

  task automatic test_timeout();
    int st, bz; logic [31:0] a, w; logic we; bit stb, bub, ok;
    run_instr(1'b1, 1'b0, 2'b01, 32'h3004, 32'h0, 32'h48, 32'h0, 5'd9, 0, 32'h0, 1'b0, 1'b0,
              st, bz, a, we, w, stb, bub, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL timeout_retire: got no retire required retire within bound"); end
    n_checks++; if (bz !== TB_TIMEOUT || st !== TB_TIMEOUT + 1) begin n_fail++; $display("FAIL timeout_cycles: got req=%0d stalls=%0d required %0d/%0d", bz, st, TB_TIMEOUT, TB_TIMEOUT + 1); end
    n_checks++; if (bus_error !== 1'b1) begin n_fail++; $display("FAIL timeout_error: got %b required 1", bus_error); end
    n_checks++; if (wb_read_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL timeout_rdata: got %h required DEADBEEF", wb_read_data); end
    run_instr(1'b1, 1'b0, 2'b11, 32'h0, 32'h0, 32'h4C, 32'h99, 5'd2, 0, 32'h0, 1'b0, 1'b0,
              st, bz, a, we, w, stb, bub, ok);
    n_checks++; if (st !== 0 || wb_imm_ext !== 32'h99 || bus_error !== 1'b1) begin n_fail++; $display("FAIL timeout_resume: got stalls=%0d imm=%h err=%b required 0/99/1", st, wb_imm_ext, bus_error); end
  endtask

  task automatic test_wb_clear();
    int st, bz; logic [31:0] a, w; logic we; bit stb, bub, ok;
    run_instr(1'b1, 1'b0, 2'b01, 32'h5000, 32'h0, 32'h50, 32'h0, 5'd11, 2, 32'h12345678, 1'b1, 1'b0,
              st, bz, a, we, w, stb, bub, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL clear_retire: got no retire required retire within bound"); end
    n_checks++; if (wb_reg_write !== 1'b0 || wb_rd !== 5'd0) begin n_fail++; $display("FAIL clear_wb: got %b/%0d required 0/0", wb_reg_write, wb_rd); end
    n_checks++; if (bus_error !== 1'b1) begin n_fail++; $display("FAIL clear_error_kept: got %b required 1", bus_error); end
  endtask

  task automatic test_reset_busy();
    set_instr(1'b1, 1'b0, 2'b01, 32'h6000, 32'h0, 32'h60, 32'h0, 5'd4);
    @(posedge clk); #1;
    n_checks++; if (bus_req !== 1'b1) begin n_fail++; $display("FAIL rstbusy_setup: got req=%b required 1", bus_req); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++; if (bus_req !== 1'b0 || bus_error !== 1'b0 || wb_read_data !== 32'h0) begin n_fail++; $display("FAIL rstbusy_state: got req=%b err=%b rdata=%h required 0/0/0", bus_req, bus_error, wb_read_data); end
    #1;
    n_checks++; if (mem_stall !== 1'b1) begin n_fail++; $display("FAIL rstbusy_idle_load_stall: got %b required 1", mem_stall); end
    set_instr(1'b1, 1'b0, 2'b00, 32'h77, 32'h0, 32'h64, 32'h0, 5'd6);
    bus_ack = 1'b1; bus_rdata = 32'hABCD1234;
    @(negedge clk);
    n_checks++; if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL rstbusy_idle_stall: got %b required 0", mem_stall); end
    @(posedge clk); #1;
    bus_ack = 1'b0;
    n_checks++; if (bus_req !== 1'b0 || wb_read_data !== 32'h0 || wb_alu_result !== 32'h77) begin n_fail++; $display("FAIL rstbusy_late_ack: got req=%b rdata=%h alu=%h required 0/0/77", bus_req, wb_read_data, wb_alu_result); end
  endtask

  task automatic test_random();
    int st, bz, kind, dly, exp_busy, exp_stalls;
    logic [31:0] a, w, alu, wd, pc4, imm, rdata, exp_rdata;
    logic we, rw, mw, exp_err, acc, acked;
    logic [1:0] rs;
    logic [4:0] rd;
    bit stb, bub, ok;
    exp_rdata = 32'h0; exp_err = 1'b0;
    for (int t = 0; t < 60; t++) begin
      kind = $urandom_range(0, 4);
      rw = 1'($urandom_range(0, 1)); mw = 1'b0;
      case (kind)
        0: rs = 2'b00;
        1: rs = 2'b01;
        2: begin mw = 1'b1; rs = ($urandom_range(0, 1) == 1) ? 2'b00 : 2'b10; end
        3: rs = 2'b10;
        default: rs = 2'b11;
      endcase
      alu = $urandom; wd = $urandom; pc4 = $urandom; imm = $urandom; rdata = $urandom;
      rd = 5'($urandom_range(0, 31));
      dly = $urandom_range(0, 6);
      run_instr(rw, mw, rs, alu, wd, pc4, imm, rd, dly, rdata, 1'b0, 1'b1,
                st, bz, a, we, w, stb, bub, ok);
      acc = (kind == 1) || (kind == 2);
      acked = (dly >= 1) && (dly <= TB_TIMEOUT);
      exp_busy = acc ? (acked ? dly : TB_TIMEOUT) : 0;
      exp_stalls = acc ? exp_busy + 1 : 0;
      if (acc && !acked) exp_err = 1'b1;
      if (kind == 1) exp_rdata = acked ? rdata : 32'hDEADBEEF;
      n_checks++; if (!ok) begin n_fail++; $display("FAIL rand_retire[%0d]: got no retire required retire", t); end
      n_checks++; if (st !== exp_stalls || bz !== exp_busy) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d/%0d required %0d/%0d", t, st, bz, exp_stalls, exp_busy); end
      n_checks++; if (wb_reg_write !== rw || wb_rd !== rd || wb_result_src !== rs) begin n_fail++; $display("FAIL rand_wb_ctrl[%0d]: got %b/%0d/%0d required %b/%0d/%0d", t, wb_reg_write, wb_rd, wb_result_src, rw, rd, rs); end
      n_checks++; if (wb_alu_result !== alu || wb_pc_plus_4 !== pc4 || wb_imm_ext !== imm) begin n_fail++; $display("FAIL rand_wb_data[%0d]: got %h/%h/%h required %h/%h/%h", t, wb_alu_result, wb_pc_plus_4, wb_imm_ext, alu, pc4, imm); end
      n_checks++; if (wb_read_data !== exp_rdata) begin n_fail++; $display("FAIL rand_rdata[%0d]: got %h required %h", t, wb_read_data, exp_rdata); end
      n_checks++; if (bus_error !== exp_err) begin n_fail++; $display("FAIL rand_error[%0d]: got %b required %b", t, bus_error, exp_err); end
      if (acc) begin
        n_checks++; if (a !== {alu[31:2], 2'b00} || we !== mw || w !== wd || stb !== 1'b1) begin n_fail++; $display("FAIL rand_bus[%0d]: got %h/%b/%h/%b required %h/%b/%h/1", t, a, we, w, stb, {alu[31:2], 2'b00}, mw, wd); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_timeout();
    test_wb_clear();
    test_reset_busy();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
